pwm_handshake_rx: RTL and testbench

Responder end of the four-phase req/ack duty-cycle transfer used between the CPU clock domain and the PWM/DAC clock domain. It runs entirely in the PWM clock domain and treats `req` and `duty_cycle` as asynchronous inputs. It synchronizes `req`, captures the held duty-cycle word, and returns `ack` for the initiator to synchronize. The captured word drives `pwm_dac` through the CPU/synth source mux.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/sync_bit.sv | 26 ++
 rtl/pwm_handshake_rx.sv | 127 ++++++++++++
 tb/tb_pwm_handshake_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-cycle path: default word width and the
// responder FSM state encoding.
package pwm_pkg;

    // Default duty-cycle width, also used by pwm_controller and pwm_dac.
    localparam int BUS_WIDTH = 12;

    // Responder handshake states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with asynchronous reset. Used for the
// incoming req level here and for the returning ack level on the initiator.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous level through the flop chain; stage 0 is the
    // only flop that may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_handshake_rx.sv
// Responder end of the four-phase req/ack duty-cycle transfer, running in the
// PWM clock domain. req is synchronized; duty_cycle is sampled only once the
// synchronized req proves it has been held stable.
//
// Handshake: the initiator raises req with duty_cycle held stable, this block
// answers with ack=1 after capturing, the initiator drops req, and this block
// drops ack. A new request is only accepted once the block is back in IDLE.
module pwm_handshake_rx
    import pwm_pkg::*;
#(
    parameter int BUS_WIDTH   = pwm_pkg::BUS_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [BUS_WIDTH-1:0] duty_cycle,
    input  logic                 err_clr,
    output logic                 ack,
    output logic [BUS_WIDTH-1:0] pwm_duty_cycle,
    output logic                 update,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic                 protocol_err,
    output rx_state_t            dbg_state
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic      req_s;
    rx_state_t state_q;
    rx_state_t state_d;
    logic      capture_en;
    logic      err_set;
    logic      cnt_inc;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    // Next-state decode and the one-cycle action strobes for each state.
    always_comb begin
        state_d    = state_q;
        capture_en = 1'b0;
        err_set    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (req_s) begin
                    capture_en = 1'b1;
                    state_d    = ACK;
                end else begin
                    // Request withdrawn before we answered: flag it, keep old word.
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!req_s) begin
                    cnt_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; ack is decoded from the next state so it comes straight
    // from a flop and is high exactly while the state is ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack     <= 1'b0;
        end else begin
            state_q <= state_d;
            ack     <= (state_d == ACK);
        end
    end

    // Capture register and its single-cycle update strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_duty_cycle <= '0;
            update         <= 1'b0;
        end else begin
            update <= capture_en;
            if (capture_en) begin
                pwm_duty_cycle <= duty_cycle;
            end
        end
    end

    // Completed-transfer counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (cnt_inc) begin
            xfer_count <= xfer_count + CNT_ONE;
        end
    end

    // Sticky protocol error; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (err_set) begin
            protocol_err <= 1'b1;
        end else if (err_clr) begin
            protocol_err <= 1'b0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_handshake_rx.sv
// Directed bench for pwm_handshake_rx. Drivers push the expected captured word
// into exp_q; a monitor pops and compares on every update pulse. A second
// instance with a 2-bit counter exercises counter wrap.
module tb_pwm_handshake_rx;
    import pwm_pkg::*;

    localparam int W  = 12;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [W-1:0] duty_cycle;
    logic         err_clr;

    logic         ack;
    logic [W-1:0] pwm_duty_cycle;
    logic         update;
    logic [15:0]  xfer_count;
    logic         protocol_err;
    rx_state_t    dbg_state;

    logic         w_ack;
    logic [W-1:0] w_pwm_duty_cycle;
    logic         w_update;
    logic [1:0]   w_xfer_count;
    logic         w_protocol_err;
    rx_state_t    w_dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           exp_count = 0;

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    pwm_handshake_rx #(
        .BUS_WIDTH   (W),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .duty_cycle     (duty_cycle),
        .err_clr        (err_clr),
        .ack            (ack),
        .pwm_duty_cycle (pwm_duty_cycle),
        .update         (update),
        .xfer_count     (xfer_count),
        .protocol_err   (protocol_err),
        .dbg_state      (dbg_state)
    );

    pwm_handshake_rx #(
        .BUS_WIDTH   (W),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (2)
    ) dut_w (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .duty_cycle     (duty_cycle),
        .err_clr        (err_clr),
        .ack            (w_ack),
        .pwm_duty_cycle (w_pwm_duty_cycle),
        .update         (w_update),
        .xfer_count     (w_xfer_count),
        .protocol_err   (w_protocol_err),
        .dbg_state      (w_dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // On each update pulse, the captured word must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && update) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_update: got 0x%0h with empty expected queue at %0t",
                         pwm_duty_cycle, $time);
            end else begin
                check("sb_duty", 32'(pwm_duty_cycle), 32'(exp_q.pop_front()));
                check("sb_ack_with_update", 32'(ack), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Full four-phase transfer with cycle-exact ack timing checks.
    task automatic do_xfer(input logic [W-1:0] word);
        exp_q.push_back(word);
        duty_cycle = word;
        req        = 1'b1;
        repeat (SS + 1) tick();
        check("ack_not_early", 32'(ack), 32'd0);
        tick();
        check("ack_rise", 32'(ack), 32'd1);
        check("update_pulse", 32'(update), 32'd1);
        tick();
        check("update_one_cycle", 32'(update), 32'd0);
        req = 1'b0;
        repeat (SS) tick();
        check("ack_hold", 32'(ack), 32'd1);
        tick();
        exp_count++;
        check("ack_fall", 32'(ack), 32'd0);
        check("xfer_count", 32'(xfer_count), 32'(exp_count));
        repeat (2) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] words [3];
        logic         ack_seen;
        words[0] = 12'h000;
        words[1] = 12'hFFF;
        words[2] = 12'h7FF;

        rst        = 1'b1;
        req        = 1'b0;
        duty_cycle = '0;
        err_clr    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_duty", 32'(pwm_duty_cycle), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        check("rst_count", 32'(xfer_count), 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Single transfer
        do_xfer(12'hA5C);
        check("single_duty", 32'(pwm_duty_cycle), 32'hA5C);

        // Back-to-back transfers; the 2-bit counter instance wraps on the last
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                check("wrap_pre_count", 32'(w_xfer_count), 32'd3);
            end
            do_xfer(words[i]);
            check("b2b_duty", 32'(pwm_duty_cycle), 32'(words[i]));
        end
        check("b2b_count", 32'(xfer_count), 32'd4);
        check("b2b_err", 32'(protocol_err), 32'd0);
        check("wrap_count", 32'(w_xfer_count), 32'd0);
        check("wrap_duty", 32'(w_pwm_duty_cycle), 32'h7FF);
        check("wrap_err", 32'(w_protocol_err), 32'd0);
        check("wrap_ack", 32'(w_ack), 32'd0);

        // Glitch request: one cycle at the first flop reaches CAPTURE after
        // req_s has already dropped again, so it must abort.
        duty_cycle = 12'h123;
        req        = 1'b1;
        tick();
        req      = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        check("glitch_no_ack", 32'(ack_seen), 32'd0);
        check("glitch_err", 32'(protocol_err), 32'd1);
        check("glitch_duty_kept", 32'(pwm_duty_cycle), 32'h7FF);
        check("glitch_state_idle", 32'(dbg_state), 32'(IDLE));
        check("glitch_count_kept", 32'(xfer_count), 32'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(protocol_err), 32'd0);

        // Error priority: err_clr in the same cycle as the CAPTURE abort
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();
        check("prio_in_capture", 32'(dbg_state), 32'(CAPTURE));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("prio_err_set_wins", 32'(protocol_err), 32'd1);
        check("prio_state_idle", 32'(dbg_state), 32'(IDLE));
        repeat (2) tick();

        // Reset mid-ACK with req held high, then recapture
        exp_q.push_back(12'h3C3);
        duty_cycle = 12'h3C3;
        req        = 1'b1;
        repeat (SS + 2) tick();
        check("pre_rst_ack", 32'(ack), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_duty", 32'(pwm_duty_cycle), 32'd0);
        check("rst_mid_count", 32'(xfer_count), 32'd0);
        check("rst_mid_err", 32'(protocol_err), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        exp_count = 0;
        exp_q.push_back(12'h3C3);
        @(negedge clk);
        rst = 1'b0;
        repeat (SS + 1) tick();
        check("recap_ack_not_early", 32'(ack), 32'd0);
        tick();
        check("recap_ack", 32'(ack), 32'd1);
        check("recap_duty", 32'(pwm_duty_cycle), 32'h3C3);
        tick();
        req = 1'b0;
        repeat (SS + 1) tick();
        exp_count++;
        check("recap_ack_fall", 32'(ack), 32'd0);
        check("recap_count", 32'(xfer_count), 32'(exp_count));
        repeat (2) tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
